sram_req_ctrl: RTL and testbench

Single-port request controller that sits directly upstream of the synchronous single-port `sram` block and drives its `ce_b`/`we_b`/`addr_in`/`data_in` pins. It converts a valid/ready request stream into SRAM accesses and captures the one-cycle-late read data into a response FIFO with valid/ready backpressure. Optionally, after reset it zero-fills the whole array before accepting traffic.

---
 rtl/sram_req_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - request stream to single-port SRAM controller with response FIFO and optional zero-fill
//
// Ports:
//   clk, rstb                           clock, synchronous active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                  request stream (write or read)
//   rsp_valid/rsp_ready/rsp_rdata       read response stream, oldest first
//   init_done                           zero-fill finished, requests accepted
//   sram_ce_b/sram_we_b/sram_addr/
//   sram_wdata                          registered SRAM pin drive
//   sram_rdata                          SRAM data_out, valid the cycle after a read edge
module sram_req_ctrl #(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 1,
    parameter int RSP_DEPTH = 4,
    parameter int INIT_EN   = 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [$clog2(DEPTH)-1:0]     req_addr,
    input  logic [WIDTH*8-1:0]           req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH*8-1:0]           rsp_rdata,
    output logic                         init_done,
    output logic                         sram_ce_b,
    output logic                         sram_we_b,
    output logic [$clog2(DEPTH)-1:0]     sram_addr,
    output logic [WIDTH*8-1:0]           sram_wdata,
    input  logic [WIDTH*8-1:0]           sram_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = WIDTH * 8;
    localparam int PW = $clog2(RSP_DEPTH);
    // Occupancy sum can reach RSP_DEPTH + 2, so give it two spare bits.
    localparam int CW = PW + 2;
    localparam logic [AW:0] FILL_END = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // One bit wider than the address so the "all words written" value is representable.
    logic [AW:0]     fill_cnt;
    logic            fill_wr;
    logic            accept;
    // rd_pipe[0]: read on the SRAM pins this cycle; rd_pipe[1]: its data on sram_rdata.
    logic [1:0]      rd_pipe;
    logic [CW-1:0]   occupancy;

    logic [DW-1:0]   fifo_mem [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     fifo_count;
    logic            push;
    logic            pop;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_wr = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (INIT_EN == 0) begin
                    state_d = ST_RUN;
                end else if (fill_cnt == FILL_END) begin
                    // Last fill write is on the pins during this cycle; open for traffic next.
                    state_d = ST_RUN;
                end else begin
                    fill_wr = 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_done = (state_q == ST_RUN);

    // Credit counts queued responses plus reads still in the SRAM pipe, all registered,
    // so the consumer's rsp_ready never reaches req_ready combinationally.
    assign occupancy = CW'(fifo_count) + CW'(rd_pipe[0]) + CW'(rd_pipe[1]);
    assign req_ready = init_done && (occupancy < CW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sram_ce_b  <= 1'b1;
            sram_we_b  <= 1'b1;
            sram_addr  <= '0;
            sram_wdata <= '0;
            fill_cnt   <= '0;
            rd_pipe    <= 2'b00;
        end else begin
            rd_pipe <= {rd_pipe[0], accept && !req_we};
            if (fill_wr) begin
                sram_ce_b  <= 1'b0;
                sram_we_b  <= 1'b0;
                sram_addr  <= fill_cnt[AW-1:0];
                sram_wdata <= '0;
                fill_cnt   <= fill_cnt + 1'b1;
            end else if (accept) begin
                sram_ce_b  <= 1'b0;
                sram_we_b  <= !req_we;
                sram_addr  <= req_addr;
                sram_wdata <= req_wdata;
            end else begin
                // Idle: deselect but keep address/data stable.
                sram_ce_b  <= 1'b1;
                sram_we_b  <= 1'b1;
            end
        end
    end

    assign push      = rd_pipe[1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];

    // Credit guarantees a push never lands on a full FIFO.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_rdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - directed self-checking bench for sram_req_ctrl
module tb_sram_req_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rstb;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic       sram_ce_b;
    logic       sram_we_b;
    logic [3:0] sram_addr;
    logic [7:0] sram_wdata;
    logic [7:0] sram_rdata;

    logic       rstb0;
    logic       n_req_valid;
    logic       n_req_ready;
    logic       n_req_we;
    logic [3:0] n_req_addr;
    logic [7:0] n_req_wdata;
    logic       n_rsp_valid;
    logic       n_rsp_ready;
    logic [7:0] n_rsp_rdata;
    logic       n_init_done;
    logic       n_sram_ce_b;
    logic       n_sram_we_b;
    logic [3:0] n_sram_addr;
    logic [7:0] n_sram_wdata;
    logic [7:0] n_sram_rdata;
    int         n_access = 0;

    sram_req_ctrl #(.DEPTH(16), .WIDTH(1), .RSP_DEPTH(4), .INIT_EN(1)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .sram_ce_b(sram_ce_b), .sram_we_b(sram_we_b), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    sram_req_ctrl #(.DEPTH(16), .WIDTH(1), .RSP_DEPTH(4), .INIT_EN(0)) dut0 (
        .clk(clk), .rstb(rstb0),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
        .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_rdata(n_rsp_rdata),
        .init_done(n_init_done),
        .sram_ce_b(n_sram_ce_b), .sram_we_b(n_sram_we_b), .sram_addr(n_sram_addr),
        .sram_wdata(n_sram_wdata), .sram_rdata(n_sram_rdata)
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    logic       preload;
    logic [7:0] sram_mem [16];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= 8'hF0 | 8'(i);
        end else if (!sram_ce_b) begin
            if (!sram_we_b) sram_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= sram_mem[sram_addr];
        end
    end

    always @(negedge clk) begin
        if (rstb0 && !n_sram_ce_b) n_access++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstb = 1'b0; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        tick; tick;
        preload = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, init_done, sram_ce_b, sram_we_b} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00011", {req_ready, rsp_valid, init_done, sram_ce_b, sram_we_b});
        end
        checks++;
        if ({sram_addr, sram_wdata, rsp_rdata} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 00000", {sram_addr, sram_wdata, rsp_rdata});
        end
    endtask

    task automatic test_no_init;
        rstb0 = 1'b0;
        n_req_valid = 1'b0; n_req_we = 1'b0; n_req_addr = '0; n_req_wdata = '0;
        n_rsp_ready = 1'b0; n_sram_rdata = '0;
        tick; tick;
        checks++;
        if ({n_init_done, n_req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL noinit_reset got %b exp 00", {n_init_done, n_req_ready});
        end
        rstb0 = 1'b1;
        tick;
        checks++;
        if ({n_init_done, n_req_ready, n_sram_ce_b} !== 3'b111) begin
            errors++;
            $display("FAIL noinit_ready got %b exp 111", {n_init_done, n_req_ready, n_sram_ce_b});
        end
        tick; tick;
        checks++;
        if (n_access !== 0) begin
            errors++;
            $display("FAIL noinit_access got %0d exp 0", n_access);
        end
    endtask

    task automatic test_fill;
        int nz;
        rstb = 1'b1;
        tick;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({sram_ce_b, sram_we_b, sram_addr, sram_wdata, init_done} !== {2'b00, 4'(i), 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL fill_%0d got ce%b we%b a%h d%h done%b exp ce0 we0 a%h d00 done0",
                         i, sram_ce_b, sram_we_b, sram_addr, sram_wdata, init_done, 4'(i));
            end
            tick;
        end
        checks++;
        if ({init_done, req_ready, sram_ce_b} !== 3'b111) begin
            errors++;
            $display("FAIL fill_done got %b exp 111", {init_done, req_ready, sram_ce_b});
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (sram_mem[i] !== 8'h00) nz++;
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL fill_mem got %0d nonzero words exp 0", nz);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
        tick;
        req_valid = 1'b0;
        checks++;
        if ({sram_ce_b, sram_we_b, sram_addr} !== {2'b01, 4'd7}) begin
            errors++;
            $display("FAIL fill_rd_issue got ce%b we%b a%h exp ce0 we1 a7", sram_ce_b, sram_we_b, sram_addr);
        end
        tick;
        tick;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL fill_rd7 got v%b d%h exp v1 d00", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_read;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
        tick;
        req_we = 1'b0;
        checks++;
        if ({sram_ce_b, sram_we_b, sram_addr, sram_wdata} !== {2'b00, 4'd3, 8'hA5}) begin
            errors++;
            $display("FAIL wr_issue got ce%b we%b a%h d%h exp ce0 we0 a3 da5", sram_ce_b, sram_we_b, sram_addr, sram_wdata);
        end
        tick;
        req_valid = 1'b0;
        checks++;
        if ({sram_ce_b, sram_we_b, rsp_valid} !== 3'b010) begin
            errors++;
            $display("FAIL rd_issue got %b exp 010", {sram_ce_b, sram_we_b, rsp_valid});
        end
        tick;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_early got %b exp 0", rsp_valid);
        end
        tick;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL rd_a5 got v%b d%h exp v1 da5", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_pop got %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        int acc;
        int not_ready;
        logic [3:0] naddr;
        logic a;
        not_ready = 0;
        req_valid = 1'b1; req_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 4'(i); req_wdata = 8'h30 + 8'(i);
            if (req_ready !== 1'b1) not_ready++;
            tick;
        end
        checks++;
        if (not_ready !== 0) begin
            errors++;
            $display("FAIL bp_writes got %0d stalls exp 0", not_ready);
        end
        req_we = 1'b0; rsp_ready = 1'b0;
        acc = 0; naddr = 4'd0;
        for (int k = 0; k < 8; k++) begin
            req_addr = naddr;
            a = req_ready;
            tick;
            if (a) begin acc++; naddr++; end
        end
        req_valid = 1'b0;
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL bp_accepts got %0d exp 4", acc);
        end
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata} !== {2'b01, 8'h30}) begin
            errors++;
            $display("FAIL bp_stall got rdy%b v%b d%h exp rdy0 v1 d30", req_ready, rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h30 + 8'(j)}) begin
                errors++;
                $display("FAIL bp_drain_%0d got v%b d%h exp v1 d%h", j, rsp_valid, rsp_rdata, 8'h30 + 8'(j));
            end
            tick;
        end
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_after got %b exp 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_back_to_back;
        int issued;
        int got;
        int stalls;
        int bubbles;
        logic a;
        issued = 0; got = 0; stalls = 0; bubbles = 0;
        rsp_ready = 1'b1; req_we = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (issued < 8) begin
                req_valid = 1'b1; req_addr = 4'(issued);
                if (req_ready !== 1'b1) stalls++;
            end else begin
                req_valid = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_rdata !== 8'h30 + 8'(got)) begin
                    errors++;
                    $display("FAIL b2b_data_%0d got %h exp %h", got, rsp_rdata, 8'h30 + 8'(got));
                end
                got++;
            end else if (got > 0 && got < 8) begin
                bubbles++;
            end
            a = req_valid && req_ready;
            tick;
            if (a) issued++;
        end
        req_valid = 1'b0;
        checks++;
        if ({32'(got), 32'(stalls), 32'(bubbles)} !== {32'd8, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL b2b_stream got resp%0d stalls%0d bubbles%0d exp resp8 stalls0 bubbles0", got, stalls, bubbles);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fill;
        int n;
        rstb = 1'b0;
        tick;
        rstb = 1'b1;
        tick;
        n = 0;
        while (!(sram_ce_b === 1'b0 && sram_addr === 4'd9) && n < 30) begin
            tick; n++;
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL mid_reach9 got %0d cycles exp 9", n);
        end
        rstb = 1'b0;
        tick;
        checks++;
        if ({sram_ce_b, sram_addr, init_done} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got ce%b a%h done%b exp ce1 a0 done0", sram_ce_b, sram_addr, init_done);
        end
        rstb = 1'b1;
        tick;
        checks++;
        if ({sram_ce_b, sram_we_b, sram_addr} !== {2'b00, 4'd0}) begin
            errors++;
            $display("FAIL mid_restart got ce%b we%b a%h exp ce0 we0 a0", sram_ce_b, sram_we_b, sram_addr);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 40) begin
            tick; n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL mid_done got %0d cycles exp 16", n);
        end
    endtask

    initial begin
        rstb0 = 1'b0;
        test_reset;
        test_no_init;
        test_fill;
        test_write_read;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_fill;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
